// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I opcode constants, NOP word and fetch state type
package rv32i_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HALT} fetch_state_t;

endpackage

// File: rtl/imem.sv
// rtl/imem.sv - word-indexed instruction ROM with asynchronous read
import rv32i_pkg::*;

module imem #(
  parameter int                          IMEM_DEPTH = 256,
  parameter int                          AW         = $clog2(IMEM_DEPTH),
  // ROM image as packed words; word i lives at bits [32*i +: 32]
  parameter logic [32*IMEM_DEPTH-1:0]    IMEM_INIT  = {IMEM_DEPTH{NOP}}
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  logic [31:0] rom [IMEM_DEPTH];

  for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
    assign rom[i] = IMEM_INIT[32*i +: 32];
  end

  assign data = rom[addr];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - RV32I fetch stage: PC, ROM read, next-PC select, halt and instret
import rv32i_pkg::*;

module ifetch #(
  parameter logic [31:0]                 RESET_PC   = 32'h0000_0000,
  parameter int                          IMEM_DEPTH = 256,
  parameter logic [32*IMEM_DEPTH-1:0]    IMEM_INIT  = {IMEM_DEPTH{NOP}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_t state;
  logic [31:0]  rom_word;
  logic         in_range;

  imem #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .AW         (AW),
    .IMEM_INIT  (IMEM_INIT)
  ) u_imem (
    .addr (pc[AW+1:2]),
    .data (rom_word)
  );

  // in range when every address bit above the ROM word index is zero
  assign in_range    = ((pc >> (AW + 2)) == 32'd0);
  assign instr       = in_range ? rom_word : NOP;
  assign opcode      = instr[6:0];
  assign pc_plus4    = pc + 32'd4;
  assign instr_valid = (state == RUN) && !stall && in_range;
  assign halted      = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      state   <= RUN;
      fault   <= 1'b0;
      instret <= 32'd0;
    end else if (state == HALT) begin
      pc      <= pc;
    end else if (stall) begin
      pc      <= pc;
    end else if (!in_range) begin
      state   <= HALT;
      fault   <= 1'b1;
    end else if (opcode == OP_SYSTEM) begin
      // the SYSTEM instruction itself retires before the core stops
      instret <= instret + 32'd1;
      state   <= HALT;
      fault   <= 1'b0;
    end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
      state   <= HALT;
      fault   <= 1'b1;
    end else if (branch_taken) begin
      pc      <= branch_target;
      instret <= instret + 32'd1;
    end else begin
      pc      <= pc_plus4;
      instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed scoreboard bench for ifetch
import rv32i_pkg::*;

module tb_ifetch;

  localparam logic [31:0] W0  = 32'h0010_0093;
  localparam logic [31:0] W1  = 32'h0020_0113;
  localparam logic [31:0] W2  = 32'h0030_0193;
  localparam logic [31:0] W3  = 32'h0040_0213;
  localparam logic [31:0] W16 = 32'h0050_0293;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic logic [32*32-1:0] make_img_a();
    logic [32*32-1:0] img;
    for (int i = 0; i < 32; i++) img[32*i +: 32] = NOP;
    img[32*0 +: 32]  = W0;
    img[32*1 +: 32]  = W1;
    img[32*2 +: 32]  = W2;
    img[32*3 +: 32]  = W3;
    img[32*4 +: 32]  = ECALL;
    img[32*16 +: 32] = W16;
    return img;
  endfunction

  localparam logic [32*32-1:0] IMG_A = make_img_a();
  localparam logic [32*4-1:0]  IMG_B = {W3, W2, W1, W0};

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, stall_a = 1'b0, bt_a = 1'b0;
  logic [31:0] tgt_a = 32'd0;
  logic        rst_b = 1'b1;
  logic        stall_b = 1'b0, bt_b = 1'b0;
  logic [31:0] tgt_b = 32'd0;

  logic [31:0] pc_a, pc4_a, instr_a, ret_a, pc_b, pc4_b, instr_b, ret_b;
  logic [6:0]  op_a, op_b;
  logic        v_a, h_a, f_a, v_b, h_b, f_b;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0), .IMEM_DEPTH(32), .IMEM_INIT(IMG_A)) dut_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .branch_taken(bt_a), .branch_target(tgt_a),
    .pc(pc_a), .pc_plus4(pc4_a), .instr(instr_a), .opcode(op_a), .instr_valid(v_a),
    .halted(h_a), .fault(f_a), .instret(ret_a)
  );

  ifetch #(.RESET_PC(32'h0), .IMEM_DEPTH(4), .IMEM_INIT(IMG_B)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .branch_taken(bt_b), .branch_target(tgt_b),
    .pc(pc_b), .pc_plus4(pc4_b), .instr(instr_b), .opcode(op_b), .instr_valid(v_b),
    .halted(h_b), .fault(f_b), .instret(ret_b)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic [31:0] pc;
    logic [31:0] ret;
    logic [31:0] instr;
    logic        v;
    logic        h;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] ex);
    vectors++;
    assert (obs === ex) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, ex);
    end
  endtask

  // drive one cycle of stimulus, queue the post-edge expectation, then check it
  task automatic step(input string tag, input bit sel, input logic r, input logic st,
                      input logic bt, input logic [31:0] tgt, input logic [31:0] e_pc,
                      input logic [31:0] e_ret, input logic [31:0] e_instr,
                      input logic e_v, input logic e_h, input logic e_f);
    exp_t e;
    if (!sel) begin
      rst_a = r; stall_a = st; bt_a = bt; tgt_a = tgt;
    end else begin
      rst_b = r;
    end
    e.tag = tag; e.sel = sel; e.pc = e_pc; e.ret = e_ret; e.instr = e_instr;
    e.v = e_v; e.h = e_h; e.f = e_f;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!e.sel) begin
      chk(e.tag, "pc", pc_a, e.pc);
      chk(e.tag, "pc_plus4", pc4_a, e.pc + 32'd4);
      chk(e.tag, "instret", ret_a, e.ret);
      chk(e.tag, "instr", instr_a, e.instr);
      chk(e.tag, "opcode", {25'd0, op_a}, {25'd0, e.instr[6:0]});
      chk(e.tag, "valid", {31'd0, v_a}, {31'd0, e.v});
      chk(e.tag, "halted", {31'd0, h_a}, {31'd0, e.h});
      chk(e.tag, "fault", {31'd0, f_a}, {31'd0, e.f});
    end else begin
      chk(e.tag, "pc", pc_b, e.pc);
      chk(e.tag, "instret", ret_b, e.ret);
      chk(e.tag, "instr", instr_b, e.instr);
      chk(e.tag, "valid", {31'd0, v_b}, {31'd0, e.v});
      chk(e.tag, "halted", {31'd0, h_b}, {31'd0, e.h});
      chk(e.tag, "fault", {31'd0, f_b}, {31'd0, e.f});
    end
  endtask

  initial begin
    // sequential run into ECALL, then reset out of halt
    step("reset",    0, 1, 0, 0, 0,     32'h00, 0, W0,    1, 0, 0);
    step("seq1",     0, 0, 0, 0, 0,     32'h04, 1, W1,    1, 0, 0);
    step("seq2",     0, 0, 0, 0, 0,     32'h08, 2, W2,    1, 0, 0);
    step("seq3",     0, 0, 0, 0, 0,     32'h0C, 3, W3,    1, 0, 0);
    step("seq4",     0, 0, 0, 0, 0,     32'h10, 4, ECALL, 1, 0, 0);
    step("ecall",    0, 0, 0, 0, 0,     32'h10, 5, ECALL, 0, 1, 0);
    step("halt_hold",0, 0, 0, 1, 32'h40,32'h10, 5, ECALL, 0, 1, 0);
    step("rst_halt", 0, 1, 0, 0, 0,     32'h00, 0, W0,    1, 0, 0);

    // branch redirect with no bubble
    step("br_a",     0, 0, 0, 0, 0,     32'h04, 1, W1,    1, 0, 0);
    step("br_b",     0, 0, 0, 0, 0,     32'h08, 2, W2,    1, 0, 0);
    step("br_take",  0, 0, 0, 1, 32'h40,32'h40, 3, W16,   1, 0, 0);
    step("br_next",  0, 0, 0, 0, 0,     32'h44, 4, NOP,   1, 0, 0);

    // misaligned branch target
    step("rst_mis",  0, 1, 0, 0, 0,     32'h00, 0, W0,    1, 0, 0);
    step("mis_a",    0, 0, 0, 0, 0,     32'h04, 1, W1,    1, 0, 0);
    step("mis_b",    0, 0, 0, 0, 0,     32'h08, 2, W2,    1, 0, 0);
    step("mis_take", 0, 0, 0, 1, 32'h42,32'h08, 2, W2,    0, 1, 1);
    step("mis_hold", 0, 0, 0, 0, 0,     32'h08, 2, W2,    0, 1, 1);

    // stall, release, and reset while stalled
    step("rst_stl",  0, 1, 0, 0, 0,     32'h00, 0, W0,    1, 0, 0);
    step("stl_a",    0, 0, 0, 0, 0,     32'h04, 1, W1,    1, 0, 0);
    step("stall1",   0, 0, 1, 0, 0,     32'h04, 1, W1,    0, 0, 0);
    step("stall2",   0, 0, 1, 1, 32'h40,32'h04, 1, W1,    0, 0, 0);
    step("stall3",   0, 0, 1, 0, 0,     32'h04, 1, W1,    0, 0, 0);
    step("release",  0, 0, 0, 0, 0,     32'h08, 2, W2,    1, 0, 0);
    step("stall4",   0, 0, 1, 0, 0,     32'h08, 2, W2,    0, 0, 0);
    step("rst_instl",0, 1, 1, 0, 0,     32'h00, 0, W0,    0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0,     32'h04, 1, W1,    1, 0, 0);

    // out-of-range fetch on a 4-word ROM
    step("b_reset",  1, 1, 0, 0, 0,     32'h00, 0, W0,    1, 0, 0);
    step("b_seq1",   1, 0, 0, 0, 0,     32'h04, 1, W1,    1, 0, 0);
    step("b_seq2",   1, 0, 0, 0, 0,     32'h08, 2, W2,    1, 0, 0);
    step("b_seq3",   1, 0, 0, 0, 0,     32'h0C, 3, W3,    1, 0, 0);
    step("b_oor",    1, 0, 0, 0, 0,     32'h10, 4, NOP,   0, 0, 0);
    step("b_fault",  1, 0, 0, 0, 0,     32'h10, 4, NOP,   0, 1, 1);
    step("b_hold",   1, 0, 0, 0, 0,     32'h10, 4, NOP,   0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
